// File: rtl/window_pkg.sv
// Shared constants for the 3x3 window generator: pixel/window widths,
// slot offsets inside the packed window and the frame-tracking states.
package window_pkg;
  localparam int PIX_W = 12;
  localparam int WIN_W = 108;

  localparam int CENTER_LSB    = 96;
  localparam int LEFT_LSB      = 84;
  localparam int RIGHT_LSB     = 72;
  localparam int UP_LSB        = 60;
  localparam int DOWN_LSB      = 48;
  localparam int UPLEFT_LSB    = 36;
  localparam int UPRIGHT_LSB   = 24;
  localparam int DOWNLEFT_LSB  = 12;
  localparam int DOWNRIGHT_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;
endpackage

// File: rtl/line_buffer.sv
// One-line pixel store. Written at the current column on accept; the read port
// is registered and prefetches the column that the next accepted pixel will use.
module line_buffer
  import window_pkg::*;
#(
  parameter int DEPTH = 160
) (
  input  logic                       clk,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_wr_addr,
  input  logic [PIX_W-1:0]           i_wr_data,
  input  logic [$clog2(DEPTH)-1:0]   i_rd_addr,
  output logic [PIX_W-1:0]           o_rd_data
);
  logic [PIX_W-1:0] r_mem [DEPTH];
  logic [PIX_W-1:0] r_rd;

  // Read and write addresses always differ (DEPTH >= 3), so no bypass needed.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
      r_rd             <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd;
endmodule

// File: rtl/window_3x3_generator.sv
// Raster-scan 3x3 neighbourhood generator with two chained line buffers.
// Optional macro WINDOW_COORD_OUT_EN adds registered center_x/center_y outputs.
module window_3x3_generator
  import window_pkg::*;
#(
  parameter int IMG_WIDTH  = 160,
  parameter int IMG_HEIGHT = 120
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PIX_W-1:0]  pix_in,
  input  logic              pix_valid,
  input  logic              frame_start,
  output logic [WIN_W-1:0]  color_data,
  output logic              window_valid,
  output logic              frame_done
`ifdef WINDOW_COORD_OUT_EN
  ,
  output logic [15:0]       center_x,
  output logic [15:0]       center_y
`endif
);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  state_t                    r_state, w_state_nxt;
  logic [XW-1:0]             r_x, w_x_eff, w_x_nxt;
  logic [YW-1:0]             r_y, w_y_eff, w_y_nxt;
  logic                      w_acc, w_fire, w_last;
  logic [PIX_W-1:0]          w_lb0_q, w_lb1_q;
  logic [2:0][PIX_W-1:0]     w_col;
  logic [2:0][1:0][PIX_W-1:0] r_tap;
  logic [WIN_W-1:0]          w_win;
  logic [WIN_W-1:0]          r_color;
  logic                      r_win_vld, r_done;

  // A frame_start pixel is accepted in any state and re-bases the frame at (0,0).
  assign w_acc   = pix_valid && (frame_start || (r_state != ST_IDLE));
  assign w_x_eff = frame_start ? '0 : r_x;
  assign w_y_eff = frame_start ? '0 : r_y;
  assign w_fire  = w_acc && (w_x_eff >= XW'(2)) && (w_y_eff >= YW'(2));
  assign w_last  = w_acc && (w_x_eff == X_LAST) && (w_y_eff == Y_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    if (w_acc) begin
      if (w_last) begin
        w_state_nxt = ST_IDLE;
        w_x_nxt     = '0;
        w_y_nxt     = '0;
      end else if (w_x_eff == X_LAST) begin
        w_x_nxt     = '0;
        w_y_nxt     = w_y_eff + 1'b1;
        w_state_nxt = (w_y_eff >= YW'(1)) ? ST_RUN : ST_PRIME;
      end else begin
        w_x_nxt     = w_x_eff + 1'b1;
        w_y_nxt     = w_y_eff;
        w_state_nxt = frame_start ? ST_PRIME : r_state;
      end
    end
  end

  // lb0 holds row y-1 and feeds lb1, which therefore holds row y-2.
  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
    .clk       (clk),
    .i_we      (w_acc),
    .i_wr_addr (w_x_eff),
    .i_wr_data (pix_in),
    .i_rd_addr (w_x_nxt),
    .o_rd_data (w_lb0_q)
  );

  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk       (clk),
    .i_we      (w_acc),
    .i_wr_addr (w_x_eff),
    .i_wr_data (w_lb0_q),
    .i_rd_addr (w_x_nxt),
    .o_rd_data (w_lb1_q)
  );

  // Column x of rows y-2, y-1, y; taps hold columns x-1 ([0]) and x-2 ([1]).
  assign w_col = {pix_in, w_lb0_q, w_lb1_q};

  always_ff @(posedge clk) begin
    if (w_acc) begin
      for (int r = 0; r < 3; r++) r_tap[r] <= {r_tap[r][0], w_col[r]};
    end
  end

  always_comb begin
    w_win = '0;
    w_win[CENTER_LSB    +: PIX_W] = r_tap[1][0];
    w_win[LEFT_LSB      +: PIX_W] = r_tap[1][1];
    w_win[RIGHT_LSB     +: PIX_W] = w_lb0_q;
    w_win[UP_LSB        +: PIX_W] = r_tap[0][0];
    w_win[DOWN_LSB      +: PIX_W] = r_tap[2][0];
    w_win[UPLEFT_LSB    +: PIX_W] = r_tap[0][1];
    w_win[UPRIGHT_LSB   +: PIX_W] = w_lb1_q;
    w_win[DOWNLEFT_LSB  +: PIX_W] = r_tap[2][1];
    w_win[DOWNRIGHT_LSB +: PIX_W] = pix_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_color   <= '0;
      r_win_vld <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_win_vld <= w_fire;
      r_done    <= w_last;
      if (w_fire) r_color <= w_win;
    end
  end

  assign color_data   = r_color;
  assign window_valid = r_win_vld;
  assign frame_done   = r_done;

`ifdef WINDOW_COORD_OUT_EN
  logic [15:0] r_cx, r_cy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (w_fire) begin
      r_cx <= 16'(w_x_eff) - 16'd1;
      r_cy <= 16'(w_y_eff) - 16'd1;
    end
  end

  assign center_x = r_cx;
  assign center_y = r_cy;
`endif
endmodule
